sdft_seq: RTL and testbench



---
 rtl/sdft_pkg.sv | 19 +
 rtl/sdft_twiddle_rom.sv | 70 +++++++
 rtl/sdft_seq.sv | 147 ++++++++++++++
 tb/tb_sdft_seq.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdft_pkg.sv
// Shared types and elaboration helpers for the sliding DFT sequencer.
package sdft_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sdft_state_t;

    // Bits needed to index n entries (n a power of two, n >= 2).
    function automatic int idx_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sdft_twiddle_rom.sv
// Twiddle table W^k = cos(2*pi*k/N) + j*sin(2*pi*k/N), unity = 2^(twiddle_width-2).
// Entries are computed at elaboration with integer fixed-point Taylor series
// folded into the first quadrant, so the quarter points come out exact.
module sdft_twiddle_rom
    import sdft_pkg::*;
#(
    parameter int freq_bins     = 16,
    parameter int twiddle_width = 8
) (
    input  logic [idx_width(freq_bins)-1:0] k,
    output logic [twiddle_width-1:0]        cos_q,
    output logic [twiddle_width-1:0]        sin_q
);

    localparam longint ONE_Q30    = 64'sd1 << 30;
    localparam longint TWO_PI_Q30 = 64'sd6746518852;

    // Rounded, clipped cos(2*pi*idx/N) scaled to unity; sin uses idx + 3N/4.
    function automatic int twiddle_cos(input int idx);
        longint unity, limit, x, x2, term, acc, mag;
        int     m, q, j;
        bit     neg;
        unity = 64'sd1 << (twiddle_width - 2);
        limit = (64'sd1 << (twiddle_width - 1)) - 1;
        q     = freq_bins / 4;
        m     = idx % freq_bins;
        if (m < q) begin
            j = m;             neg = 1'b0;
        end else if (m < 2 * q) begin
            j = 2 * q - m;     neg = 1'b1;
        end else if (m < 3 * q) begin
            j = m - 2 * q;     neg = 1'b1;
        end else begin
            j = freq_bins - m; neg = 1'b0;
        end
        if (j == 0) begin
            mag = unity;
        end else if (j == q) begin
            mag = 0;
        end else begin
            x    = (longint'(j) * TWO_PI_Q30) / longint'(freq_bins);
            x2   = (x * x) >>> 30;
            term = ONE_Q30;
            acc  = ONE_Q30;
            for (int n = 1; n <= 7; n++) begin
                term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
                acc  = acc + term;
            end
            mag = (acc * unity + (64'sd1 << 29)) >>> 30;
        end
        if (mag > limit) begin
            mag = limit;
        end
        return neg ? -int'(mag) : int'(mag);
    endfunction

    logic [twiddle_width-1:0] cos_tab [freq_bins];
    logic [twiddle_width-1:0] sin_tab [freq_bins];

    for (genvar i = 0; i < freq_bins; i++) begin : g_entry
        localparam int COS_V = twiddle_cos(i);
        localparam int SIN_V = twiddle_cos(i + 3 * freq_bins / 4);
        assign cos_tab[i] = COS_V[twiddle_width-1:0];
        assign sin_tab[i] = SIN_V[twiddle_width-1:0];
    end

    assign cos_q = cos_tab[k];
    assign sin_q = sin_tab[k];

endmodule

// File: rtl/sdft_seq.sv
// Time-multiplexed sliding DFT: one accepted sample launches a sweep that
// rotates every bin through a single shared complex multiplier, one bin per clock.
//
//   state | meaning
//   IDLE  | ready for a sample; capture it, form delta, advance delay line
//   SWEEP | update bin k this cycle, k = 0 .. N-1, then pulse done
module sdft_seq
    import sdft_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int freq_bins     = 16,
    parameter int twiddle_width = 8,
    parameter int bin_width     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [data_width-1:0]           sample,
    input  logic                            sample_valid,
    output logic                            sample_ready,
    output logic                            done,
    output logic                            overrun,
    input  logic [idx_width(freq_bins)-1:0] rd_bin,
    output logic [bin_width-1:0]            rd_real,
    output logic [bin_width-1:0]            rd_imag
);

    localparam int KW = idx_width(freq_bins);
    localparam int DW = data_width + 1;
    localparam int AW = ((bin_width > DW) ? bin_width : DW) + 1;
    localparam int PW = AW + twiddle_width;
    localparam int SH = twiddle_width - 2;
    localparam logic [KW-1:0] K_LAST = KW'(freq_bins - 1);
    localparam logic signed [PW:0] BIN_MAX =
        {{(PW - bin_width + 2){1'b0}}, {(bin_width - 1){1'b1}}};
    localparam logic signed [PW:0] BIN_MIN =
        {{(PW - bin_width + 2){1'b1}}, {(bin_width - 1){1'b0}}};

    sdft_state_t                                state;
    logic [KW-1:0]                              wp;
    logic [KW-1:0]                              k;
    logic signed [DW-1:0]                       delta;
    logic [freq_bins-1:0][data_width-1:0]       delay_mem;
    logic [freq_bins-1:0][bin_width-1:0]        bin_re;
    logic [freq_bins-1:0][bin_width-1:0]        bin_im;

    logic signed [twiddle_width-1:0] cos_q;
    logic signed [twiddle_width-1:0] sin_q;
    logic signed [AW-1:0]            a_val;
    logic signed [AW-1:0]            b_val;
    logic signed [PW-1:0]            p_ac;
    logic signed [PW-1:0]            p_bs;
    logic signed [PW-1:0]            p_as;
    logic signed [PW-1:0]            p_bc;
    logic signed [PW:0]              re_full;
    logic signed [PW:0]              im_full;
    logic signed [PW:0]              re_shift;
    logic signed [PW:0]              im_shift;
    logic signed [bin_width-1:0]     re_next;
    logic signed [bin_width-1:0]     im_next;

    function automatic logic [bin_width-1:0] saturate(input logic signed [PW:0] v);
        logic [bin_width-1:0] r;
        if (v > BIN_MAX) begin
            r = {1'b0, {(bin_width - 1){1'b1}}};
        end else if (v < BIN_MIN) begin
            r = {1'b1, {(bin_width - 1){1'b0}}};
        end else begin
            r = v[bin_width-1:0];
        end
        return r;
    endfunction

    sdft_twiddle_rom #(
        .freq_bins     (freq_bins),
        .twiddle_width (twiddle_width)
    ) u_rom (
        .k     (k),
        .cos_q (cos_q),
        .sin_q (sin_q)
    );

    assign sample_ready = (state == IDLE);

    // Complex rotate of (X_k + delta) by W^k at full precision, floor shift, saturate.
    always_comb begin
        a_val    = AW'($signed(bin_re[k])) + AW'(delta);
        b_val    = AW'($signed(bin_im[k]));
        p_ac     = PW'(a_val) * PW'(cos_q);
        p_bs     = PW'(b_val) * PW'(sin_q);
        p_as     = PW'(a_val) * PW'(sin_q);
        p_bc     = PW'(b_val) * PW'(cos_q);
        re_full  = (PW + 1)'(p_ac) - (PW + 1)'(p_bs);
        im_full  = (PW + 1)'(p_as) + (PW + 1)'(p_bc);
        re_shift = re_full >>> SH;
        im_shift = im_full >>> SH;
        re_next  = saturate(re_shift);
        im_next  = saturate(im_shift);
    end

    // Sequencer, delay line, bin storage and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wp        <= '0;
            k         <= '0;
            delta     <= '0;
            delay_mem <= '0;
            bin_re    <= '0;
            bin_im    <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            rd_real   <= '0;
            rd_imag   <= '0;
        end else begin
            // Reads see the array before this edge's bin write.
            rd_real <= bin_re[rd_bin];
            rd_imag <= bin_im[rd_bin];
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        delta         <= {sample[data_width-1], sample}
                                       - {delay_mem[wp][data_width-1], delay_mem[wp]};
                        delay_mem[wp] <= sample;
                        wp            <= wp + 1'b1;
                        k             <= '0;
                        state         <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (sample_valid) begin
                        overrun <= 1'b1;
                    end
                    bin_re[k] <= re_next;
                    bin_im[k] <= im_next;
                    k         <= k + 1'b1;
                    if (k == K_LAST) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdft_seq.sv
// Bench for sdft_seq: spectrum vectors, handshake corner cases, and randomized
// samples against a sweep-level reference model.
module tb_sdft_seq;

    localparam int  N    = 16;
    localparam int  TW   = 8;
    localparam real PI_R = 3.14159265358979;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        done;
    logic        overrun;
    logic [3:0]  rd_bin;
    logic [15:0] rd_real;
    logic [15:0] rd_imag;

    logic [7:0]  sample2;
    logic        sample_valid2;
    logic        sample_ready2;
    logic        done2;
    logic        overrun2;
    logic [3:0]  rd_bin2;
    logic [9:0]  rd_real2;
    logic [9:0]  rd_imag2;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    longint m_re [N];
    longint m_im [N];
    int     m_dly [N];
    int     m_wp;
    int     tw_c [N];
    int     tw_s [N];

    typedef struct {
        string name;
        int    pattern;
        int    nsamp;
        int    bin;
        int    exp_re;
        int    exp_im;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_count++;

    sdft_seq dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .done         (done),
        .overrun      (overrun),
        .rd_bin       (rd_bin),
        .rd_real      (rd_real),
        .rd_imag      (rd_imag)
    );

    sdft_seq #(.bin_width(10)) dut10 (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample2),
        .sample_valid (sample_valid2),
        .sample_ready (sample_ready2),
        .done         (done2),
        .overrun      (overrun2),
        .rd_bin       (rd_bin2),
        .rd_real      (rd_real2),
        .rd_imag      (rd_imag2)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic longint sat(input longint v, input int bw);
        longint hi, lo;
        hi = (64'sd1 << (bw - 1)) - 1;
        lo = -(64'sd1 << (bw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_re[i] = 0; m_im[i] = 0; m_dly[i] = 0;
        end
        m_wp = 0;
    endfunction

    // One whole sliding-DFT step: X_k <- (X_k + x_new - x_old) * W^k.
    function automatic void model_push(input int x, input int bw);
        longint d, a, b, r, im;
        d = x - m_dly[m_wp];
        m_dly[m_wp] = x;
        m_wp = (m_wp + 1) % N;
        for (int kk = 0; kk < N; kk++) begin
            a = m_re[kk] + d;
            b = m_im[kk];
            r  = (a * tw_c[kk] - b * tw_s[kk]) >>> (TW - 2);
            im = (a * tw_s[kk] + b * tw_c[kk]) >>> (TW - 2);
            m_re[kk] = sat(r, bw);
            m_im[kk] = sat(im, bw);
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && !sample_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!sample_ready) chk("ready_timeout", sample_ready, 1);
    endtask

    task automatic send(input int x);
        wait_ready();
        sample = 8'(x);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        model_push(x, 16);
    endtask

    task automatic read_bin(input int b, output longint re, output longint im);
        rd_bin = 4'(b);
        @(posedge clk); #1;
        re = longint'($signed(rd_real));
        im = longint'($signed(rd_imag));
    endtask

    task automatic wait_ready2();
        for (int i = 0; i < 200 && !sample_ready2; i++) begin
            @(posedge clk); #1;
        end
        if (!sample_ready2) chk("ready10_timeout", sample_ready2, 1);
    endtask

    task automatic send2(input int x);
        wait_ready2();
        sample2 = 8'(x);
        sample_valid2 = 1'b1;
        @(posedge clk); #1;
        sample_valid2 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        longint re, im, pre_re, pre_im;
        int n, bad, nz, cnt0, x;

        for (int i = 0; i < N; i++) begin
            tw_c[i] = rnd($cos(2.0 * PI_R * i / N) * 64.0);
            tw_s[i] = rnd($sin(2.0 * PI_R * i / N) * 64.0);
        end

        vecs[0] = '{"imp_b0",   0, 1,  0,   10,   0};
        vecs[1] = '{"imp_b4",   0, 1,  4,    0,  10};
        vecs[2] = '{"imp_b8",   0, 1,  8,  -10,   0};
        vecs[3] = '{"imp_b12",  0, 1, 12,    0, -10};
        vecs[4] = '{"const_b0", 1, 16, 0,  160,   0};
        vecs[5] = '{"const_b4", 1, 16, 4,    0,   0};
        vecs[6] = '{"const_b8", 1, 16, 8,    0,   0};
        vecs[7] = '{"const_b12",1, 16, 12,   0,   0};
        vecs[8] = '{"alt_b8",   2, 40, 8, -160,   0};
        vecs[9] = '{"alt_b0",   2, 40, 0,    0,   0};

        reset = 1'b1; sample = '0; sample_valid = 1'b0; rd_bin = '0;
        sample2 = '0; sample_valid2 = 1'b0; rd_bin2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        chk("rst_ready",   sample_ready, 1);
        chk("rst_done",    done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_rd_real", rd_real, 0);
        chk("rst_rd_imag", rd_imag, 0);

        // Spectrum vectors
        for (int v = 0; v < 10; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].nsamp; i++) begin
                case (vecs[v].pattern)
                    0:       send(10);
                    1:       send(10);
                    default: send((i % 2 == 0) ? -10 : 10);
                endcase
            end
            wait_ready();
            read_bin(vecs[v].bin, re, im);
            chk($sformatf("%s_re", vecs[v].name), re, vecs[v].exp_re);
            chk($sformatf("%s_im", vecs[v].name), im, vecs[v].exp_im);
        end

        // Done latency and ready window for one impulse
        do_reset();
        sample = 8'd10; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        model_push(10, 16);
        chk("ready_low_after_accept", sample_ready, 0);
        n = 0; bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
            if (sample_ready) bad++;
        end
        chk("done_latency", n + 1, 17);
        chk("ready_during_sweep", bad, 0);
        chk("ready_with_done", sample_ready, 1);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);

        // Overrun: offer a sample 3 cycles into a sweep
        do_reset();
        send(20);
        repeat (2) @(posedge clk);
        #1;
        sample = 8'd99; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk("overrun_set", overrun, 1);
        wait_ready();
        chk("overrun_sticky", overrun, 1);
        send(-7);
        wait_ready();
        for (int b = 0; b < N; b += 5) begin
            read_bin(b, re, im);
            chk($sformatf("ovr_b%0d_re", b), re, m_re[b]);
            chk($sformatf("ovr_b%0d_im", b), im, m_im[b]);
        end
        chk("overrun_still", overrun, 1);

        // Randomized samples, including back-to-back acceptance during done
        do_reset();
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge clk); #1;
            end
            x = int'($urandom_range(0, 255)) - 128;
            send(x);
        end
        wait_ready();
        for (int b = 0; b < N; b++) begin
            read_bin(b, re, im);
            chk($sformatf("rand_b%0d_re", b), re, m_re[b]);
            chk($sformatf("rand_b%0d_im", b), im, m_im[b]);
        end

        // Read of the bin being written returns the pre-update value
        rd_bin = 4'd3;
        wait_ready();
        pre_re = m_re[3]; pre_im = m_im[3];
        sample = 8'd55; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        model_push(55, 16);
        repeat (4) @(posedge clk);
        #1;
        chk("rd_pre_update_re", longint'($signed(rd_real)), pre_re);
        chk("rd_pre_update_im", longint'($signed(rd_imag)), pre_im);
        @(posedge clk); #1;
        chk("rd_post_update_re", longint'($signed(rd_real)), m_re[3]);
        chk("rd_post_update_im", longint'($signed(rd_imag)), m_im[3]);

        // Reset at k=5 abandons the sweep
        wait_ready();
        sample = 8'd20; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cnt0 = done_count;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("abort_ready", sample_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_overrun", overrun, 0);
        chk("abort_rd_real", rd_real, 0);
        nz = 0;
        for (int b = 0; b < N; b++) begin
            read_bin(b, re, im);
            if (re != 0 || im != 0) nz++;
        end
        chk("abort_bins_zero", nz, 0);
        chk("abort_no_done", done_count - cnt0, 0);

        // Narrow accumulator saturates instead of wrapping
        for (int i = 0; i < 5; i++) send2(100);
        wait_ready2();
        rd_bin2 = 4'd0;
        @(posedge clk); #1;
        chk("bw10_b0_5_re", longint'($signed(rd_real2)), 500);
        chk("bw10_b0_5_im", longint'($signed(rd_imag2)), 0);
        for (int i = 0; i < 3; i++) send2(100);
        wait_ready2();
        @(posedge clk); #1;
        chk("bw10_b0_sat_re", longint'($signed(rd_real2)), 511);
        chk("bw10_b0_sat_im", longint'($signed(rd_imag2)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
